apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB requester (initiator) for the team's APB fabric; drives psel/penable/paddr/pwrite/pwdata/pprot toward an APB completer such as the team's APB slave memory.
- Accepts one command at a time from a local valid/ready command port and runs the IDLE -> SETUP -> ACCESS sequence.
- Returns read data and error status on a one-cycle response strobe.
- A programmable ACCESS-phase timeout stops a missing pready from hanging the bus.

Parameters:
ADDR_WIDTH, `D_WIDTH (32), width of paddr/cmd_addr
DATA_WIDTH, `D_WIDTH (32), width of pwdata/prdata/cmd_wdata/rsp_rdata
TIMEOUT_CYCLES, 16, max ACCESS cycles waiting for pready; 0 disables the timeout

Ports:
pclk  in  1  the block's single clock
preset  in  1  reset; synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted on pclk edge when cmd_valid&&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
cmd_prot  in  3  protection attributes, passed to pprot
rsp_valid  out  1  one-cycle completion strobe
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_slverr  out  1  completer error or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_WIDTH  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data; 0 during reads
pprot  out  3  APB protection
pready  in  1  completer ready
prdata  in  DATA_WIDTH  completer read data
pslverr  in  1  completer error, valid only with pready in ACCESS

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-high. While preset=1 at a pclk edge: state=IDLE, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, pprot=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, timeout counter=0.
- Reset mid-transfer: the bus drops on the next edge, the in-flight command is discarded and no response is issued.
- FSM states are IDLE, SETUP and ACCESS. All APB outputs and rsp_* come from flops.
- IDLE: cmd_ready=1. On acceptance, capture cmd_* into paddr/pwrite/pwdata/pprot and go to SETUP. The edge after acceptance shows psel=1, penable=0.
- SETUP: lasts exactly one cycle, then ACCESS (penable=1). pready is ignored in SETUP.
- ACCESS: paddr/pwrite/pwdata/pprot stay stable. Wait while pready=0.
  - Completion is an edge with pready=1 in ACCESS.
  - Next cycle: rsp_valid=1 for exactly one cycle.
  - rsp_rdata = prdata for reads, 0 for writes.
  - rsp_slverr = pslverr; rsp_timeout=0.
- Back-to-back: cmd_ready = (IDLE) or (ACCESS && pready). This is a combinational path from pready.
  - If a command is accepted at the completion edge, go straight to SETUP: psel stays 1, penable drops to 0, and the new address/data load.
  - Otherwise go to IDLE: psel=0, penable=0.
- Minimum transfer: 2 bus cycles. Accept-to-rsp_valid is 3 edges with zero wait states.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter is cleared on entering ACCESS and increments on each ACCESS edge with pready=0.
  - When the count equals TIMEOUT_CYCLES and pready=0, abort to IDLE: psel=0, penable=0.
  - The abort response is rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
  - No back-to-back acceptance occurs on a timeout edge.
  - pready=1 on the same edge the limit is hit counts as a normal completion.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. TIMEOUT_CYCLES=0 means wait forever.
- cmd_* may change freely while cmd_ready=0. They are sampled only at acceptance.

Decomposition:
- Shared package apb_pkg:
  - typedef enum apb_state_e {IDLE, SETUP, ACCESS}
  - PPROT bit-index constants: PRIV=0, NONSEC=1, INSTR=2
  - typedef struct apb_cmd_t {write, addr, wdata, prot}
- One sub-module, apb_master_timer: the timeout counter with clear/inc/expired signals, parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Reset with preset=1 mid-ACCESS -> next edge psel=penable=0, no rsp_valid; after release cmd_ready=1.
2. Write addr=0x10, data=0xDEADBEEF, prot=3'b010, completer pready=1 immediately -> SETUP then ACCESS with paddr=0x10, pwrite=1, pprot=010. rsp_valid on the 3rd edge after acceptance with slverr=0, rdata=0.
3. Read addr=0x10, completer holds pready=0 for 4 ACCESS cycles and returns prdata=0xDEADBEEF -> penable high for 5 cycles, address stable, rsp_rdata=0xDEADBEEF.
4. Two reads (0x4, 0x8) with cmd_valid held high -> psel stays 1 across both, penable 1,0,1. Two rsp_valid pulses return data in order.
5. Read with pready=1, pslverr=1 -> rsp_slverr=1, rsp_timeout=0.
6. TIMEOUT_CYCLES=16, completer never ready -> abort after exactly 16 ACCESS cycles with rsp_slverr=1, rsp_timeout=1. Repeat with pready=1 on the 16th edge -> normal completion.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM states, PPROT bit positions and the command record.
`ifndef D_WIDTH
`define D_WIDTH 32
`endif

package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH = `D_WIDTH;
    localparam int unsigned APB_DATA_WIDTH = `D_WIDTH;

    // APB transfer phases
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // PPROT bit positions
    localparam int unsigned PPROT_PRIV   = 0;
    localparam int unsigned PPROT_NONSEC = 1;
    localparam int unsigned PPROT_INSTR  = 2;

    // One requester command as presented on the local command port
    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_DATA_WIDTH-1:0] wdata;
        logic [2:0]                prot;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master_timer.sv
// ACCESS-phase watchdog: counts wait cycles and flags the edge that reaches the limit.
module apb_master_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
    // Expiry fires on the increment that would make the count reach the limit,
    // so exactly TIMEOUT_CYCLES ACCESS cycles elapse before the abort.
    localparam logic [CW-1:0] LIMIT_M1 =
        (TIMEOUT_CYCLES == 32'd0) ? {CW{1'b0}} : CW'(TIMEOUT_CYCLES - 32'd1);

    logic [CW-1:0] count_r;
    logic          expired_s;

    assign expired_s = (TIMEOUT_CYCLES != 32'd0) && inc && (count_r == LIMIT_M1);
    assign expired   = expired_s;

    // Wait-cycle counter, cleared when ACCESS is entered
    always_ff @(posedge pclk) begin
        if (preset) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (inc && !expired_s) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time through IDLE -> SETUP -> ACCESS, with
// a registered one-cycle response strobe and an optional ACCESS timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [2:0]            pprot,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);

    apb_state_e            state_r, state_next_s;
    logic                  psel_r, psel_next_s;
    logic                  penable_r, penable_next_s;
    logic [ADDR_WIDTH-1:0] paddr_r, paddr_next_s;
    logic                  pwrite_r, pwrite_next_s;
    logic [DATA_WIDTH-1:0] pwdata_r, pwdata_next_s;
    logic [2:0]            pprot_r, pprot_next_s;
    logic                  rsp_valid_r, rsp_valid_next_s;
    logic [DATA_WIDTH-1:0] rsp_rdata_r, rsp_rdata_next_s;
    logic                  rsp_slverr_r, rsp_slverr_next_s;
    logic                  rsp_timeout_r, rsp_timeout_next_s;

    logic cmd_ready_s;
    logic cmd_accept_s;
    logic timer_clear_s;
    logic timer_inc_s;
    logic timer_expired_s;

    // Ready in IDLE, or in ACCESS on the completing edge for back-to-back issue
    assign cmd_ready_s   = (state_r == IDLE) || ((state_r == ACCESS) && pready);
    assign cmd_accept_s  = cmd_valid && cmd_ready_s;
    assign timer_clear_s = (state_r == SETUP);
    assign timer_inc_s   = (state_r == ACCESS) && !pready;

    apb_master_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .pclk    (pclk),
        .preset  (preset),
        .clear   (timer_clear_s),
        .inc     (timer_inc_s),
        .expired (timer_expired_s)
    );

    // Next-state and next-output decode; response fields default to idle zeros
    always_comb begin
        state_next_s       = state_r;
        psel_next_s        = psel_r;
        penable_next_s     = penable_r;
        paddr_next_s       = paddr_r;
        pwrite_next_s      = pwrite_r;
        pwdata_next_s      = pwdata_r;
        pprot_next_s       = pprot_r;
        rsp_valid_next_s   = 1'b0;
        rsp_rdata_next_s   = {DATA_WIDTH{1'b0}};
        rsp_slverr_next_s  = 1'b0;
        rsp_timeout_next_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (cmd_accept_s) begin
                    state_next_s   = SETUP;
                    psel_next_s    = 1'b1;
                    penable_next_s = 1'b0;
                    paddr_next_s   = cmd_addr;
                    pwrite_next_s  = cmd_write;
                    pwdata_next_s  = cmd_write ? cmd_wdata : {DATA_WIDTH{1'b0}};
                    pprot_next_s   = cmd_prot;
                end else begin
                    psel_next_s    = 1'b0;
                    penable_next_s = 1'b0;
                end
            end
            SETUP: begin
                state_next_s   = ACCESS;
                penable_next_s = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_valid_next_s  = 1'b1;
                    rsp_rdata_next_s  = pwrite_r ? {DATA_WIDTH{1'b0}} : prdata;
                    rsp_slverr_next_s = pslverr;
                    if (cmd_accept_s) begin
                        state_next_s   = SETUP;
                        psel_next_s    = 1'b1;
                        penable_next_s = 1'b0;
                        paddr_next_s   = cmd_addr;
                        pwrite_next_s  = cmd_write;
                        pwdata_next_s  = cmd_write ? cmd_wdata : {DATA_WIDTH{1'b0}};
                        pprot_next_s   = cmd_prot;
                    end else begin
                        state_next_s   = IDLE;
                        psel_next_s    = 1'b0;
                        penable_next_s = 1'b0;
                    end
                end else if (timer_expired_s) begin
                    state_next_s       = IDLE;
                    psel_next_s        = 1'b0;
                    penable_next_s     = 1'b0;
                    rsp_valid_next_s   = 1'b1;
                    rsp_slverr_next_s  = 1'b1;
                    rsp_timeout_next_s = 1'b1;
                end else begin
                    state_next_s = ACCESS;
                end
            end
            default: begin
                state_next_s   = IDLE;
                psel_next_s    = 1'b0;
                penable_next_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transfer
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_r       <= IDLE;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            paddr_r       <= {ADDR_WIDTH{1'b0}};
            pwrite_r      <= 1'b0;
            pwdata_r      <= {DATA_WIDTH{1'b0}};
            pprot_r       <= 3'b000;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
            rsp_slverr_r  <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            psel_r        <= psel_next_s;
            penable_r     <= penable_next_s;
            paddr_r       <= paddr_next_s;
            pwrite_r      <= pwrite_next_s;
            pwdata_r      <= pwdata_next_s;
            pprot_r       <= pprot_next_s;
            rsp_valid_r   <= rsp_valid_next_s;
            rsp_rdata_r   <= rsp_rdata_next_s;
            rsp_slverr_r  <= rsp_slverr_next_s;
            rsp_timeout_r <= rsp_timeout_next_s;
        end
    end

    assign cmd_ready   = cmd_ready_s;
    assign psel        = psel_r;
    assign penable     = penable_r;
    assign paddr       = paddr_r;
    assign pwrite      = pwrite_r;
    assign pwdata      = pwdata_r;
    assign pprot       = pprot_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_slverr  = rsp_slverr_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb_master.sv
// Directed plus randomized bench for apb_master with a transaction-level model.
module tb_apb_master;
    import apb_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          pclk = 1'b0;
    logic          preset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [2:0]    cmd_prot;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [2:0]    pprot;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    int checks = 0;
    int errors = 0;

    apb_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_prot    (cmd_prot),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .paddr       (paddr),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pprot       (pprot),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    always #5 pclk = ~pclk;

    // Global time bound so the run always ends
    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive_cmd(input apb_cmd_t c);
        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        cmd_prot  = c.prot;
    endtask

    task automatic scramble_cmd();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
        cmd_prot  = 3'($urandom_range(0, 7));
    endtask

    // One isolated transfer. The model: a completer inserting 'waits' wait
    // states keeps penable high for waits+1 cycles, unless waits reaches the
    // timeout limit, in which case the bus is abandoned after TO cycles.
    task automatic run_xfer(input apb_cmd_t c, input int waits, input logic err,
                            input logic [DW-1:0] rd);
        bit            exp_to;
        int            n_acc;
        logic [DW-1:0] exp_wd;
        logic [DW-1:0] exp_rd;
        exp_to = (TO > 0) && (waits >= int'(TO));
        n_acc  = exp_to ? int'(TO) : waits + 1;
        exp_wd = c.write ? c.wdata : '0;
        exp_rd = (exp_to || c.write) ? '0 : rd;

        drive_cmd(c);
        pready = 1'b0;
        #1 chk("cmd_ready_idle", cmd_ready, 1'b1);
        step();
        scramble_cmd();
        pready  = 1'($urandom_range(0, 1));
        prdata  = DW'($urandom);
        pslverr = 1'($urandom_range(0, 1));
        chk("setup_psel", psel, 1'b1);
        chk("setup_penable", penable, 1'b0);
        chk("setup_paddr", paddr, c.addr);
        chk("setup_pwrite", pwrite, c.write);
        chk("setup_pwdata", pwdata, exp_wd);
        chk("setup_pprot", pprot, c.prot);
        step();
        for (int i = 1; i <= n_acc; i++) begin
            chk("access_psel", psel, 1'b1);
            chk("access_penable", penable, 1'b1);
            chk("access_paddr", paddr, c.addr);
            chk("access_pwdata", pwdata, exp_wd);
            chk("access_rsp_idle", rsp_valid, 1'b0);
            if (!exp_to && i == n_acc) begin
                pready  = 1'b1;
                pslverr = err;
                prdata  = rd;
            end else begin
                pready  = 1'b0;
                pslverr = 1'($urandom_range(0, 1));
                prdata  = DW'($urandom);
            end
            #1 chk("access_cmd_ready", cmd_ready, pready);
            step();
        end
        pready = 1'b0;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_slverr", rsp_slverr, exp_to ? 1'b1 : err);
        chk("rsp_timeout", rsp_timeout, exp_to);
        chk("end_psel", psel, 1'b0);
        chk("end_penable", penable, 1'b0);
        step();
        chk("rsp_one_cycle", rsp_valid, 1'b0);
    endtask

    apb_cmd_t      c, c2;
    logic [2:0]    p;
    logic [DW-1:0] d1, d2;
    int            w;

    initial begin
        preset  = 1'b1;
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        scramble_cmd();
        repeat (3) step();
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_paddr", paddr, '0);
        chk("rst_pwrite", pwrite, 1'b0);
        chk("rst_pwdata", pwdata, '0);
        chk("rst_pprot", pprot, 3'b000);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, '0);
        chk("rst_rsp_slverr", rsp_slverr, 1'b0);
        chk("rst_rsp_timeout", rsp_timeout, 1'b0);
        preset = 1'b0;
        step();
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        // Zero-wait write with NONSEC protection
        p = 3'b000;
        p[PPROT_NONSEC] = 1'b1;
        c = '{write: 1'b1, addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF, prot: p};
        run_xfer(c, 0, 1'b0, 32'h1234_5678);

        // Read with four wait states
        c = '{write: 1'b0, addr: 32'h0000_0010, wdata: 32'hFFFF_FFFF, prot: 3'b001};
        run_xfer(c, 4, 1'b0, 32'hDEAD_BEEF);

        // Back-to-back reads with cmd_valid held high
        d1 = 32'hA5A5_0004;
        d2 = 32'h5A5A_0008;
        c  = '{write: 1'b0, addr: 32'h0000_0004, wdata: 32'h0, prot: 3'b000};
        c2 = '{write: 1'b0, addr: 32'h0000_0008, wdata: 32'h0, prot: 3'b100};
        drive_cmd(c);
        #1 chk("b2b_ready0", cmd_ready, 1'b1);
        step();
        drive_cmd(c2);
        #1 chk("b2b_setup_busy", cmd_ready, 1'b0);
        chk("b2b_pen0", penable, 1'b0);
        chk("b2b_addr0", paddr, 32'h4);
        step();
        chk("b2b_pen1", penable, 1'b1);
        pready  = 1'b1;
        prdata  = d1;
        pslverr = 1'b0;
        #1 chk("b2b_ready1", cmd_ready, 1'b1);
        step();
        scramble_cmd();
        pready = 1'b0;
        chk("b2b_psel_held", psel, 1'b1);
        chk("b2b_pen_drop", penable, 1'b0);
        chk("b2b_addr1", paddr, 32'h8);
        chk("b2b_pprot1", pprot, 3'b100);
        chk("b2b_rsp1", rsp_valid, 1'b1);
        chk("b2b_data1", rsp_rdata, d1);
        step();
        chk("b2b_pen2", penable, 1'b1);
        chk("b2b_psel2", psel, 1'b1);
        chk("b2b_rsp_gap", rsp_valid, 1'b0);
        pready = 1'b1;
        prdata = d2;
        step();
        pready = 1'b0;
        chk("b2b_rsp2", rsp_valid, 1'b1);
        chk("b2b_data2", rsp_rdata, d2);
        chk("b2b_psel_end", psel, 1'b0);
        step();

        // Completer error on a zero-wait read
        c = '{write: 1'b0, addr: 32'h0000_0020, wdata: 32'h0, prot: 3'b000};
        run_xfer(c, 0, 1'b1, 32'hCAFE_F00D);

        // Completer never ready: abort after TO cycles; then ready on the last allowed edge
        run_xfer(c, int'(TO) + 8, 1'b0, 32'h1111_1111);
        run_xfer(c, int'(TO) - 1, 1'b0, 32'h2222_2222);

        // Reset in the middle of ACCESS
        drive_cmd(c);
        step();
        scramble_cmd();
        step();
        pready = 1'b0;
        step();
        chk("mid_rst_in_access", penable, 1'b1);
        preset = 1'b1;
        step();
        chk("mid_rst_psel", psel, 1'b0);
        chk("mid_rst_penable", penable, 1'b0);
        chk("mid_rst_rsp", rsp_valid, 1'b0);
        preset = 1'b0;
        pready = 1'b1;
        step();
        chk("post_rst_rsp", rsp_valid, 1'b0);
        chk("post_rst_psel", psel, 1'b0);
        pready = 1'b0;
        #1 chk("post_rst_ready", cmd_ready, 1'b1);
        step();

        // Randomized transfers against the transaction model
        for (int k = 0; k < 24; k++) begin
            c.write = 1'($urandom_range(0, 1));
            c.addr  = AW'($urandom);
            c.wdata = DW'($urandom);
            c.prot  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) begin
                w = int'($urandom_range(TO - 2, TO + 2));
            end else begin
                w = int'($urandom_range(0, 3));
            end
            run_xfer(c, w, 1'($urandom_range(0, 1)), DW'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
